// File: rtl/bomb_launch_ctrl_pkg.sv
// Shared constants and state codes for the bomb launch sequencer.
package bomb_launch_ctrl_pkg;

  localparam int BOMB_MAX_HOLD          = 3;
  localparam int BOMB_INIT_HOLD         = 1;
  localparam int BOMB_CNT_BIT_LEN       = 2;
  localparam int BOMB_FLASH_FRAMES      = 8;
  localparam int BOMB_COOLDOWN_FRAMES   = 30;
  localparam int BOMB_FRAME_CNT_BIT_LEN = 6;

  typedef enum logic [1:0] {
    BOMB_ST_IDLE     = 2'd0,
    BOMB_ST_FLASH    = 2'd1,
    BOMB_ST_COOLDOWN = 2'd2
  } bomb_st_e;

endpackage

// File: rtl/bomb_launch_ctrl_if.sv
// Game-side bus of the bomb launch sequencer: control inputs and status outputs.
interface bomb_launch_ctrl_if
  import bomb_launch_ctrl_pkg::*;
#(
  parameter int CNT_W = BOMB_CNT_BIT_LEN
);
  logic             en_i;
  logic             restart_i;
  logic             v_sync_i;
  logic             key_bomb_i;
  logic             bonus_get_i;
  logic [CNT_W-1:0] bomb_cnt_o;
  logic             clear_all_o;
  logic             flash_o;
  logic             busy_o;

  modport master (
    output en_i, restart_i, v_sync_i, key_bomb_i, bonus_get_i,
    input  bomb_cnt_o, clear_all_o, flash_o, busy_o
  );

  modport slave (
    input  en_i, restart_i, v_sync_i, key_bomb_i, bonus_get_i,
    output bomb_cnt_o, clear_all_o, flash_o, busy_o
  );
endinterface

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for an asynchronous key level plus a one-cycle
// rising-edge pulse. A held key produces exactly one pulse.
module key_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  // [0],[1] synchronize; [2] is the previous synchronized value
  logic [2:0] sync_pipe;

  // shift the raw key level through the synchronizer and history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[1:0], d};
  end

  assign rise = sync_pipe[1] & ~sync_pipe[2];
endmodule

// File: rtl/bomb_launch_ctrl.sv
// Bomb inventory and launch sequencer: launch key -> one-cycle global clear,
// then a frame-timed flash followed by a cooldown before the next launch.
module bomb_launch_ctrl
  import bomb_launch_ctrl_pkg::*;
#(
  parameter int MAX_BOMB          = BOMB_MAX_HOLD,
  parameter int INIT_BOMB         = BOMB_INIT_HOLD,
  parameter int BOMB_CNT_BIT_LEN  = bomb_launch_ctrl_pkg::BOMB_CNT_BIT_LEN,
  parameter int FLASH_FRAMES      = BOMB_FLASH_FRAMES,
  parameter int COOLDOWN_FRAMES   = BOMB_COOLDOWN_FRAMES,
  parameter int FRAME_CNT_BIT_LEN = BOMB_FRAME_CNT_BIT_LEN
) (
  input logic               clk_run,
  input logic               rst,
  bomb_launch_ctrl_if.slave bus
);
  localparam int CW = BOMB_CNT_BIT_LEN;
  localparam int FW = FRAME_CNT_BIT_LEN;

  bomb_st_e        state, state_nxt;
  logic [CW-1:0]   bomb_cnt, cnt_nxt;
  logic [FW-1:0]   frame_cnt, frame_nxt;
  logic            clear_q, clear_nxt;
  logic            flash_q, flash_nxt;
  logic            busy_q, busy_nxt;
  logic            key_rise;
  logic            vs_prev;
  logic            frame_tick;
  logic            launch;
  logic            frame_last;

  key_sync_edge u_key_sync (
    .clk  (clk_run),
    .rst  (rst),
    .d    (bus.key_bomb_i),
    .rise (key_rise)
  );

  // remember last v_sync level so a frame tick is one cycle per frame
  always_ff @(posedge clk_run or posedge rst) begin
    if (rst) vs_prev <= 1'b0;
    else     vs_prev <= bus.v_sync_i;
  end

  assign frame_tick = bus.v_sync_i & ~vs_prev;
  assign launch     = (state == BOMB_ST_IDLE) & key_rise & bus.en_i & (bomb_cnt != '0);
  // true when the next frame tick completes the current phase
  assign frame_last = (state == BOMB_ST_FLASH) ? (frame_cnt == FW'(FLASH_FRAMES - 1))
                                               : (frame_cnt == FW'(COOLDOWN_FRAMES - 1));

  // state and every output are registered; restart/en gating lives in the comb blocks
  always_ff @(posedge clk_run or posedge rst) begin
    if (rst) begin
      state     <= BOMB_ST_IDLE;
      bomb_cnt  <= CW'(INIT_BOMB);
      frame_cnt <= '0;
      clear_q   <= 1'b0;
      flash_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bomb_cnt  <= cnt_nxt;
      frame_cnt <= frame_nxt;
      clear_q   <= clear_nxt;
      flash_q   <= flash_nxt;
      busy_q    <= busy_nxt;
    end
  end

  // next state: restart wins, en_i=0 freezes, key presses outside IDLE are dropped
  always_comb begin
    state_nxt = state;
    if (bus.restart_i) begin
      state_nxt = BOMB_ST_IDLE;
    end else if (bus.en_i) begin
      case (state)
        BOMB_ST_IDLE:     if (launch)                  state_nxt = BOMB_ST_FLASH;
        BOMB_ST_FLASH:    if (frame_tick && frame_last) state_nxt = BOMB_ST_COOLDOWN;
        BOMB_ST_COOLDOWN: if (frame_tick && frame_last) state_nxt = BOMB_ST_IDLE;
        default:                                       state_nxt = BOMB_ST_IDLE;
      endcase
    end
  end

  // next outputs: inventory, frame counter and clear pulse
  always_comb begin
    cnt_nxt   = bomb_cnt;
    frame_nxt = frame_cnt;
    clear_nxt = 1'b0;
    if (bus.restart_i) begin
      cnt_nxt   = CW'(INIT_BOMB);
      frame_nxt = '0;
    end else if (bus.en_i) begin
      // launch+bonus together nets to no change, so no saturation loss at MAX
      if (launch && !bus.bonus_get_i)
        cnt_nxt = bomb_cnt - CW'(1);
      else if (bus.bonus_get_i && !launch && (bomb_cnt < CW'(MAX_BOMB)))
        cnt_nxt = bomb_cnt + CW'(1);
      clear_nxt = launch;
      if (launch)
        frame_nxt = '0;
      else if ((state != BOMB_ST_IDLE) && frame_tick)
        frame_nxt = frame_last ? '0 : frame_cnt + FW'(1);
    end
    flash_nxt = (state_nxt == BOMB_ST_FLASH);
    busy_nxt  = (state_nxt != BOMB_ST_IDLE);
  end

  assign bus.bomb_cnt_o  = bomb_cnt;
  assign bus.clear_all_o = clear_q;
  assign bus.flash_o     = flash_q;
  assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_bomb_launch_ctrl.sv
// Self-checking bench for bomb_launch_ctrl: vector table for inventory updates,
// hand sequences for launch timing, drops, freeze, restart and async reset.
// Expected clear pulses go to a scoreboard queue tagged with their cycle.
module tb_bomb_launch_ctrl;
  logic clk_run = 1'b0;
  logic rst;

  always #5 clk_run = ~clk_run;

  bomb_launch_ctrl_if bus ();

  bomb_launch_ctrl dut (
    .clk_run (clk_run),
    .rst     (rst),
    .bus     (bus)
  );

  typedef struct {
    bit en;
    bit bonus;
    int exp_cnt;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_q[$];
  int mon_e;
  vec_t tbl[5];

  always @(posedge clk_run) cyc <= cyc + 1;

  // scoreboard: every clear pulse must match the next expected cycle
  always @(negedge clk_run) begin
    if (bus.clear_all_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL clear_unexpected at_cycle=%0d expected=none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e != cyc) begin
          failures++;
          $display("FAIL clear_timing actual_cycle=%0d expected_cycle=%0d", cyc, mon_e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_run);
      #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      bus.v_sync_i = 1'b1;
      step(1);
      bus.v_sync_i = 1'b0;
      step(1);
    end
  endtask

  task automatic press(input bit expect_clear);
    bus.key_bomb_i = 1'b1;
    if (expect_clear) exp_q.push_back(cyc + 3);
    step(4);
    bus.key_bomb_i = 1'b0;
  endtask

  task automatic do_restart();
    bus.restart_i = 1'b1;
    step(1);
    bus.restart_i = 1'b0;
  endtask

  initial begin
    tbl[0] = '{en: 1'b0, bonus: 1'b1, exp_cnt: 1};
    tbl[1] = '{en: 1'b1, bonus: 1'b1, exp_cnt: 2};
    tbl[2] = '{en: 1'b1, bonus: 1'b1, exp_cnt: 3};
    tbl[3] = '{en: 1'b1, bonus: 1'b1, exp_cnt: 3};
    tbl[4] = '{en: 1'b1, bonus: 1'b1, exp_cnt: 3};

    rst             = 1'b1;
    bus.en_i        = 1'b0;
    bus.restart_i   = 1'b0;
    bus.v_sync_i    = 1'b0;
    bus.key_bomb_i  = 1'b0;
    bus.bonus_get_i = 1'b0;
    step(2);
    chk("rst_cnt",   bus.bomb_cnt_o,  1);
    chk("rst_flash", bus.flash_o,     0);
    chk("rst_busy",  bus.busy_o,      0);
    chk("rst_clear", bus.clear_all_o, 0);
    rst = 1'b0;
    step(1);
    bus.en_i = 1'b1;

    // first launch: full flash + cooldown timing
    press(1);
    chk("l1_cnt",   bus.bomb_cnt_o, 0);
    chk("l1_flash", bus.flash_o,    1);
    chk("l1_busy",  bus.busy_o,     1);
    frames(7);
    chk("l1_flash7", bus.flash_o, 1);
    frames(1);
    chk("l1_flash8", bus.flash_o, 0);
    chk("l1_busy8",  bus.busy_o,  1);
    frames(29);
    chk("l1_busy37", bus.busy_o, 1);
    frames(1);
    chk("l1_busy38", bus.busy_o, 0);

    // empty inventory: press ignored
    press(0);
    step(3);
    chk("empty_cnt",   bus.bomb_cnt_o, 0);
    chk("empty_flash", bus.flash_o,    0);
    chk("empty_busy",  bus.busy_o,     0);

    // inventory vectors from count 1
    do_restart();
    chk("restart_cnt", bus.bomb_cnt_o, 1);
    for (int i = 0; i < 5; i++) begin
      bus.en_i        = tbl[i].en;
      bus.bonus_get_i = tbl[i].bonus;
      step(1);
      bus.bonus_get_i = 1'b0;
      bus.en_i        = 1'b1;
      chk($sformatf("bonus_tbl[%0d]", i), bus.bomb_cnt_o, tbl[i].exp_cnt);
    end

    // launch and bonus in the same cycle at MAX
    bus.key_bomb_i = 1'b1;
    exp_q.push_back(cyc + 3);
    step(2);
    bus.bonus_get_i = 1'b1;
    step(1);
    bus.bonus_get_i = 1'b0;
    bus.key_bomb_i  = 1'b0;
    chk("both_cnt",   bus.bomb_cnt_o, 3);
    chk("both_flash", bus.flash_o,    1);
    frames(38);
    chk("both_idle", bus.busy_o, 0);

    // presses during FLASH and COOLDOWN are dropped
    do_restart();
    bus.bonus_get_i = 1'b1;
    step(1);
    bus.bonus_get_i = 1'b0;
    chk("drop_cnt2", bus.bomb_cnt_o, 2);
    press(1);
    chk("drop_cnt1", bus.bomb_cnt_o, 1);
    frames(3);
    press(0);
    chk("drop_flash_cnt", bus.bomb_cnt_o, 1);
    chk("drop_flash_on",  bus.flash_o,    1);
    frames(5);
    chk("drop_cool_flash", bus.flash_o, 0);
    chk("drop_cool_busy",  bus.busy_o,  1);
    press(0);
    chk("drop_cool_cnt", bus.bomb_cnt_o, 1);
    frames(30);
    chk("drop_idle", bus.busy_o, 0);
    press(1);
    chk("drop_second_cnt", bus.bomb_cnt_o, 0);
    frames(38);

    // en_i=0 freezes the flash counter and discards bonus
    do_restart();
    press(1);
    frames(3);
    bus.en_i = 1'b0;
    frames(5);
    bus.bonus_get_i = 1'b1;
    step(1);
    bus.bonus_get_i = 1'b0;
    chk("frz_flash", bus.flash_o,    1);
    chk("frz_cnt",   bus.bomb_cnt_o, 0);
    bus.en_i = 1'b1;
    frames(4);
    chk("frz_resume_flash", bus.flash_o, 1);
    frames(1);
    chk("frz_end_flash", bus.flash_o, 0);
    chk("frz_end_busy",  bus.busy_o,  1);

    // restart mid-cooldown with empty inventory
    frames(2);
    do_restart();
    chk("rs_busy",  bus.busy_o,     0);
    chk("rs_cnt",   bus.bomb_cnt_o, 1);
    chk("rs_flash", bus.flash_o,    0);

    // async reset mid-flash, no clock edge in between
    press(1);
    frames(2);
    chk("ar_pre_flash", bus.flash_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_flash", bus.flash_o,    0);
    chk("ar_busy",  bus.busy_o,     0);
    chk("ar_cnt",   bus.bomb_cnt_o, 1);
    rst = 1'b0;
    step(4);

    chk("clear_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
